// File: rtl/sample_fifo_pkg.sv
// Shared constants for the sample FIFO: default geometry and read-mode selectors.
package sample_fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 24;
  localparam int unsigned DEFAULT_DEPTH = 16;

  localparam int unsigned MODE_REG  = 0;
  localparam int unsigned MODE_FWFT = 1;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read, no reset.
module fifo_ram
  import sample_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with registered-read or first-word-fall-through output,
// level/threshold flags and sticky overflow/underflow indicators.
module sample_fifo
  import sample_fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = DEFAULT_WIDTH,
  parameter int unsigned DEPTH    = DEFAULT_DEPTH,
  parameter int unsigned FWFT     = MODE_REG,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic                    wr_en_i,
  input  logic [WIDTH-1:0]        write_data_i,
  input  logic                    rd_en_i,
  output logic [WIDTH-1:0]        read_data_o,
  output logic                    read_valid_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    almost_full_o,
  output logic                    almost_empty_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    overflow_o,
  output logic                    underflow_o,
  input  logic                    clear_err_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "sample_fifo: DEPTH must be a power of 2 and at least 2");
  end
  if (AF_LEVEL > DEPTH || AE_LEVEL > DEPTH) begin : g_bad_level
    $fatal(1, "sample_fifo: AF_LEVEL and AE_LEVEL must not exceed DEPTH");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level;
  logic             overflow_q, overflow_d, underflow_q, underflow_d;
  logic             full, empty, wr_acc, rd_acc;
  logic [WIDTH-1:0] head;

  // One extra pointer bit distinguishes full from empty at equal addresses.
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == PW'(DEPTH));
  assign empty = (level == '0);

  assign wr_acc = wr_en_i && !full && !flush_i;
  assign rd_acc = rd_en_i && !empty && !flush_i;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overflow_d  = overflow_q & ~clear_err_i;
    underflow_d = underflow_q & ~clear_err_i;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
      // A set in the same cycle as clear_err_i takes priority.
      if (wr_en_i && full)  overflow_d  = 1'b1;
      if (rd_en_i && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data (write_data_i),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (head)
  );

  if (FWFT == MODE_FWFT) begin : g_fwft
    // Mask the uninitialised array while empty so reset presents zero data.
    assign read_data_o  = empty ? '0 : head;
    assign read_valid_o = !empty;
  end else begin : g_reg
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= head;
      end
    end

    assign read_data_o  = rdata_q;
    assign read_valid_o = rvalid_q;
  end

  assign full_o         = full;
  assign empty_o        = empty;
  assign almost_full_o  = (level >= PW'(AF_LEVEL));
  assign almost_empty_o = (level <= PW'(AE_LEVEL));
  assign level_o        = level;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_sample_fifo.sv
// Directed bench for sample_fifo: registered-read instance plus an FWFT instance.
module tb_sample_fifo;

  localparam int unsigned W = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Registered-read instance
  logic         flush = 0, wr = 0, rd = 0, clr = 0;
  logic [W-1:0] wdata = '0;
  logic [W-1:0] rdata;
  logic         rvalid, full, empty, afull, aempty, ovf, unf;
  logic [2:0]   level;

  // FWFT instance
  logic         b_flush = 0, b_wr = 0, b_rd = 0, b_clr = 0;
  logic [W-1:0] b_wdata = '0;
  logic [W-1:0] b_rdata;
  logic         b_rvalid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_unf;
  logic [2:0]   b_level;

  int n_cmp = 0;
  int n_err = 0;

  sample_fifo #(.WIDTH(W), .DEPTH(4), .FWFT(0), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .wr_en_i(wr), .write_data_i(wdata),
    .rd_en_i(rd), .read_data_o(rdata), .read_valid_o(rvalid), .full_o(full),
    .empty_o(empty), .almost_full_o(afull), .almost_empty_o(aempty), .level_o(level),
    .overflow_o(ovf), .underflow_o(unf), .clear_err_i(clr)
  );

  sample_fifo #(.WIDTH(W), .DEPTH(4), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1)) u_dut_fwft (
    .clk(clk), .rst_n(rst_n), .flush_i(b_flush), .wr_en_i(b_wr), .write_data_i(b_wdata),
    .rd_en_i(b_rd), .read_data_o(b_rdata), .read_valid_o(b_rvalid), .full_o(b_full),
    .empty_o(b_empty), .almost_full_o(b_afull), .almost_empty_o(b_aempty),
    .level_o(b_level), .overflow_o(b_ovf), .underflow_o(b_unf), .clear_err_i(b_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_empty", empty, 1);
    check("rst_aempty", aempty, 1);
    check("rst_full", full, 0);
    check("rst_afull", afull, 0);
    check("rst_level", level, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rdata", rdata, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);

    // Fill, overflow, drain
    wr = 1;
    for (int i = 1; i <= 4; i++) begin
      wdata = W'(i);
      tick();
    end
    check("fill_full", full, 1);
    check("fill_level", level, 4);
    wdata = 24'h000005;
    tick();
    check("ovf_set", ovf, 1);
    check("ovf_level", level, 4);
    wr = 0;
    rd = 1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("drain_data%0d", i), rdata, i);
      check($sformatf("drain_valid%0d", i), rvalid, 1);
    end
    rd = 0;
    check("drain_empty", empty, 1);
    tick();
    check("idle_valid", rvalid, 0);
    check("idle_hold", rdata, 4);

    // Underflow and clear
    rd = 1;
    tick();
    check("unf_set", unf, 1);
    check("unf_valid", rvalid, 0);
    check("unf_level", level, 0);
    rd = 0;
    clr = 1;
    tick();
    clr = 0;
    check("unf_clear", unf, 0);
    check("ovf_clear", ovf, 0);

    // Preload two, then simultaneous traffic wrapping the pointers
    wr = 1;
    wdata = 24'd100;
    tick();
    wdata = 24'd101;
    tick();
    rd = 1;
    for (int k = 0; k < 12; k++) begin
      wdata = W'(102 + k);
      tick();
      check($sformatf("stream_data%0d", k), rdata, 100 + k);
      check($sformatf("stream_level%0d", k), level, 2);
    end
    wr = 0;
    tick();
    check("stream_tail0", rdata, 112);
    tick();
    check("stream_tail1", rdata, 113);
    rd = 0;
    check("stream_empty", empty, 1);
    check("stream_ovf", ovf, 0);
    check("stream_unf", unf, 0);

    // Threshold sweep up then down
    wr = 1;
    for (int lv = 1; lv <= 4; lv++) begin
      wdata = W'(lv);
      tick();
      check($sformatf("up_level%0d", lv), level, lv);
      check($sformatf("up_ae%0d", lv), aempty, lv <= 1);
      check($sformatf("up_af%0d", lv), afull, lv >= 3);
    end
    wr = 0;
    rd = 1;
    for (int lv = 3; lv >= 0; lv--) begin
      tick();
      check($sformatf("dn_level%0d", lv), level, lv);
      check($sformatf("dn_ae%0d", lv), aempty, lv <= 1);
      check($sformatf("dn_af%0d", lv), afull, lv >= 3);
    end
    rd = 0;

    // Flush at level 3 with a concurrent write
    wr = 1;
    for (int i = 0; i < 4; i++) begin
      wdata = W'(24'h200 + i);
      tick();
    end
    wdata = 24'h2ff;
    tick();
    wr = 0;
    rd = 1;
    tick();
    rd = 0;
    check("pre_flush_data", rdata, 24'h200);
    check("pre_flush_level", level, 3);
    flush = 1;
    wr = 1;
    wdata = 24'h999;
    tick();
    flush = 0;
    wr = 0;
    check("flush_level", level, 0);
    check("flush_empty", empty, 1);
    check("flush_ovf", ovf, 1);
    check("flush_valid", rvalid, 0);
    check("flush_hold", rdata, 24'h200);
    wr = 1;
    wdata = 24'h300;
    tick();
    wr = 0;
    rd = 1;
    tick();
    rd = 0;
    check("post_flush_data", rdata, 24'h300);

    // Flush masks underflow; set beats clear
    clr = 1;
    tick();
    clr = 0;
    flush = 1;
    rd = 1;
    tick();
    flush = 0;
    check("flush_no_unf", unf, 0);
    clr = 1;
    tick();
    clr = 0;
    rd = 0;
    check("set_beats_clr", unf, 1);

    // Reset overrides a concurrent write/read
    wr = 1;
    wdata = 24'h400;
    tick();
    wdata = 24'h401;
    tick();
    check("pre_rst_level", level, 2);
    rst_n = 0;
    rd = 1;
    wdata = 24'h402;
    tick();
    rst_n = 1;
    wr = 0;
    rd = 0;
    check("mid_rst_level", level, 0);
    check("mid_rst_rdata", rdata, 0);
    check("mid_rst_unf", unf, 0);
    check("mid_rst_valid", rvalid, 0);

    // First-word-fall-through instance
    check("fw_rst_valid", b_rvalid, 0);
    check("fw_rst_data", b_rdata, 0);
    b_wr = 1;
    b_wdata = 24'habcdef;
    tick();
    b_wr = 0;
    check("fw_data", b_rdata, 24'habcdef);
    check("fw_valid", b_rvalid, 1);
    b_rd = 1;
    tick();
    b_rd = 0;
    check("fw_pop_empty", b_empty, 1);
    check("fw_pop_valid", b_rvalid, 0);
    b_wr = 1;
    b_wdata = 24'h111;
    tick();
    b_wdata = 24'h222;
    tick();
    b_wr = 0;
    check("fw_head0", b_rdata, 24'h111);
    b_rd = 1;
    tick();
    check("fw_head1", b_rdata, 24'h222);
    tick();
    b_rd = 0;
    check("fw_final_empty", b_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sample_fifo.md
SAMPLE_FIFO -- requirements
Module: sample_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 24: data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: entry count, power of 2, >=2.
REQ-003 SHALL have parameter FWFT, default 0: 0 = registered-read mode, 1 = first-word-fall-through mode.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-2: almost-full threshold.
REQ-005 SHALL have parameter AE_LEVEL, default 2: almost-empty threshold.
REQ-006 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: synchronous active-low reset.
REQ-008 SHALL have port flush_i, input, 1: synchronous contents discard.
REQ-009 SHALL have port wr_en_i, input, 1: write request.
REQ-010 SHALL have port write_data_i, input, WIDTH: write data.
REQ-011 SHALL have port rd_en_i, input, 1: read request (FWFT=1: pop).
REQ-012 SHALL have port read_data_o, output, WIDTH: read data.
REQ-013 SHALL have port read_valid_o, output, 1: read_data_o valid.
REQ-014 SHALL have port full_o, output, 1: level == DEPTH.
REQ-015 SHALL have port empty_o, output, 1: level == 0.
REQ-016 SHALL have port almost_full_o, output, 1: level >= AF_LEVEL.
REQ-017 SHALL have port almost_empty_o, output, 1: level <= AE_LEVEL.
REQ-018 SHALL have port level_o, output, $clog2(DEPTH)+1: stored entry count.
REQ-019 SHALL have port overflow_o, output, 1: sticky write-when-full flag.
REQ-020 SHALL have port underflow_o, output, 1: sticky read-when-empty flag.
REQ-021 SHALL have port clear_err_i, input, 1: clears overflow_o and underflow_o.

Function
REQ-022 Full DEPTH capacity: pointers $clog2(DEPTH)+1 bits wide, modular wrap; level_o = wr_ptr - rd_ptr modulo 2^($clog2(DEPTH)+1).
REQ-023 Write accepted iff wr_en_i && !full_o && !flush_i; a write on full is dropped even if a read is accepted the same cycle.
REQ-024 Read accepted iff rd_en_i && !empty_o && !flush_i.
REQ-025 Simultaneous accepted read and write: level unchanged, order preserved.
REQ-026 Flags and level_o are combinational from the registered pointers and reflect an accepted operation on the cycle after it.
REQ-027 FWFT=0: read_data_o is registered with the head entry one cycle after an accepted read, with read_valid_o high for exactly that cycle; otherwise read_data_o holds its value.
REQ-028 FWFT=1: read_data_o = head entry and read_valid_o = !empty_o; an accepted read advances the head; the first write into an empty FIFO is visible the next cycle.
REQ-029 overflow_o is set on wr_en_i && full_o; underflow_o is set on rd_en_i && empty_o; both hold until clear_err_i, and a same-cycle set wins over clear.
REQ-030 flush_i: next cycle both pointers are 0 (empty, level 0) and read_valid_o is 0; memory, error flags and (FWFT=0) read_data_o are retained; same-cycle wr/rd are ignored and do not set error flags.

Reset
REQ-031 rst_n low at a clk edge: pointers 0, read_data_o 0, read_valid_o 0, overflow_o 0, underflow_o 0, so empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0 (AF_LEVEL>0), level_o=0.
REQ-032 Reset mid-operation overrides flush, write, read and clear the same cycle; memory contents are not cleared.

Structure
REQ-033 Package sample_fifo_pkg SHALL hold default WIDTH/DEPTH constants and the FWFT mode constants (MODE_REG=0, MODE_FWFT=1).
REQ-034 Storage SHALL be sub-module fifo_ram: simple dual-port, sync write, async read, with no reset on the array.
REQ-035 Elaboration SHALL fail if DEPTH is not a power of 2, or if AF_LEVEL or AE_LEVEL > DEPTH.

Verification (WIDTH=24, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1 unless stated)
REQ-036 Write 0x000001..0x000004, then a 5th write 0x000005 -> full_o=1, level_o=4, overflow_o=1; 4 reads return 1,2,3,4 with read_valid_o pulses; empty_o=1.
REQ-037 rd_en_i on empty -> underflow_o=1, read_valid_o=0, level_o=0; then clear_err_i -> underflow_o=0 next cycle.
REQ-038 Preload 2 entries, then 12 cycles of simultaneous wr/rd with an incrementing pattern -> level_o=2 every cycle, output sequence in order, pointers wrap past 8 with no error.
REQ-039 Level sweep 0->4->0 -> almost_empty_o high at levels 0-1, almost_full_o high at levels 3-4.
REQ-040 Level 3 with flush_i and wr_en_i together -> next cycle level_o=0, empty_o=1, overflow_o unchanged, write discarded.
REQ-041 FWFT=1: write 0xABCDEF to empty -> next cycle read_data_o=0xABCDEF, read_valid_o=1 with no rd_en_i; one rd_en_i -> empty_o=1, read_valid_o=0.
